// File: rtl/lsu_pkg.sv
// Shared types and helpers for the MEM-stage load/store unit.
// Optional feature macro: LSU_BP_STATS_EN (branch statistics counters in mem_stage_lsu).
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} lsu_state_t;

  // in_op encoding; at most one op class per instruction.
  localparam logic [2:0] OP_NONE   = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_JAL    = 3'd3;
  localparam logic [2:0] OP_JALR   = 3'd4;
  localparam logic [2:0] OP_BRANCH = 3'd5;

  // Access size in funct3[1:0]; funct3[2] selects zero-extension for loads.
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic int unsigned lsu_be_w(int unsigned xlen);
    return xlen / 8;
  endfunction

  function automatic int unsigned lsu_off_w(int unsigned xlen);
    return $clog2(xlen / 8);
  endfunction

  // 1 when the load/store is misaligned or its size is illegal for this XLEN.
  function automatic logic lsu_ldst_bad(logic [2:0] funct3, logic [2:0] addr_lo, logic is64);
    logic bad;
    case (funct3[1:0])
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr_lo[0];
      SZ_W:    bad = (addr_lo[1:0] != 2'b00);
      default: bad = (addr_lo != 3'b000);
    endcase
    if (funct3 == 3'b111) bad = 1'b1;
    if (!is64 && (funct3[1:0] == SZ_D || funct3 == 3'b110)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid port between the LSU (master) and memory (slave).
interface mem_stage_lsu_if #(
  parameter int unsigned XLEN = 32
) ();
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              gnt;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lanes of a load response and sign/zero-extends them.
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned OFF_W = 2
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [2:0]       funct3,
  input  logic [OFF_W-1:0] offset,
  output logic [XLEN-1:0]  data
);
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] mask;
  logic            sign;

  // Shift the addressed byte to lane 0, then mask and fill the upper bits.
  always_comb begin
    shifted = rdata >> {offset, 3'b000};
    mask    = '1;
    sign    = 1'b0;
    unique case (funct3[1:0])
      SZ_B: begin mask = XLEN'(8'hFF);         sign = shifted[7];  end
      SZ_H: begin mask = XLEN'(16'hFFFF);      sign = shifted[15]; end
      SZ_W: begin mask = XLEN'(32'hFFFF_FFFF); sign = shifted[31]; end
      default: begin mask = '1; sign = 1'b0; end
    endcase
    if (funct3[2]) sign = 1'b0;
    data = (shifted & mask) | (sign ? ~mask : '0);
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: branch resolution, alignment check, data-memory access, writeback register.
// Optional: define LSU_BP_STATS_EN to enable saturating mispredict/branch counters.
module mem_stage_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RD_W   = 5,
  parameter int unsigned STAT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [2:0]        in_funct3,
  input  logic [2:0]        in_op,
  input  logic              in_cond,
  input  logic              in_pred,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_we,
  mem_stage_lsu_if.master   dmem,
  output logic              redirect,
  output logic [XLEN-1:0]   redirect_addr,
  output logic              branch_taken,
  output logic              exc_jmp_mis,
  output logic              exc_ldst_mis,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [RD_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [STAT_W-1:0] stat_mispred,
  output logic [STAT_W-1:0] stat_branches
);
  localparam int unsigned BE_W  = lsu_be_w(XLEN);
  localparam int unsigned OFF_W = lsu_off_w(XLEN);

  lsu_state_t       state_q;
  logic [2:0]       funct3_q;
  logic [OFF_W-1:0] off_q;
  logic [RD_W-1:0]  rd_q;
  logic             we_q;

  logic            accept, is_load, is_store, is_jal, is_jalr, is_branch, is_mem, is_ctrl;
  logic            misaligned, taken;
  logic [XLEN-1:0] pc_plus4, pc_plus_imm, target, st_wdata, load_data;
  logic [BE_W-1:0] st_be;

  assign in_ready    = (state_q == IDLE);
  assign accept      = in_valid & in_ready;
  assign is_load     = (in_op == OP_LOAD);
  assign is_store    = (in_op == OP_STORE);
  assign is_jal      = (in_op == OP_JAL);
  assign is_jalr     = (in_op == OP_JALR);
  assign is_branch   = (in_op == OP_BRANCH);
  assign is_mem      = is_load | is_store;
  assign is_ctrl     = is_jal | is_jalr | is_branch;
  assign misaligned  = lsu_ldst_bad(in_funct3, in_addr[2:0], 1'(XLEN == 64));
  assign pc_plus4    = in_pc + XLEN'(4);
  assign pc_plus_imm = in_pc + in_imm;

  // Resolve control flow for the op being accepted; redirect only on a wrong prediction.
  always_comb begin
    taken  = 1'b0;
    target = pc_plus4;
    if (is_jal) begin
      taken  = 1'b1;
      target = pc_plus_imm;
    end else if (is_jalr) begin
      taken  = 1'b1;
      target = {in_addr[XLEN-1:1], 1'b0};
    end else if (is_branch && in_cond) begin
      taken  = 1'b1;
      target = pc_plus_imm;
    end
    redirect      = accept & is_ctrl & (taken != in_pred);
    redirect_addr = target;
    branch_taken  = accept & is_ctrl & taken;
    exc_jmp_mis   = redirect & (target[1:0] != 2'b00);
    exc_ldst_mis  = accept & is_mem & misaligned;
  end

  // Byte enables and store data replicated into every lane of the access size.
  always_comb begin
    st_be    = '1;
    st_wdata = in_wdata;
    unique case (in_funct3[1:0])
      SZ_B: begin st_be = BE_W'(8'h01); st_wdata = {BE_W{in_wdata[7:0]}};       end
      SZ_H: begin st_be = BE_W'(8'h03); st_wdata = {(XLEN/16){in_wdata[15:0]}}; end
      SZ_W: begin st_be = BE_W'(8'h0F); st_wdata = {(XLEN/32){in_wdata[31:0]}}; end
      default: begin st_be = '1; st_wdata = in_wdata; end
    endcase
    st_be = st_be << in_addr[OFF_W-1:0];
  end

  lsu_load_align #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_align (
    .rdata  (dmem.rdata),
    .funct3 (funct3_q),
    .offset (off_q),
    .data   (load_data)
  );

  // Access FSM with registered memory request and writeback bundle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= '0;
      dmem.be    <= '0;
      dmem.wdata <= '0;
      funct3_q   <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      wb_valid   <= 1'b0;
      wb_we      <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_mem && !misaligned) begin
              state_q    <= REQ;
              dmem.req   <= 1'b1;
              dmem.we    <= is_store;
              dmem.addr  <= {in_addr[XLEN-1:OFF_W], OFF_W'(0)};
              dmem.be    <= st_be;
              dmem.wdata <= st_wdata;
              funct3_q   <= in_funct3;
              off_q      <= in_addr[OFF_W-1:0];
              rd_q       <= in_rd;
              we_q       <= in_we & is_load;
            end else begin
              // Single-cycle ops; a faulting load/store retires without a register write.
              wb_valid <= 1'b1;
              wb_we    <= in_we & ~is_mem;
              wb_rd    <= in_rd;
              wb_data  <= (is_jal || is_jalr) ? pc_plus4 : in_addr;
            end
          end
        end
        REQ: begin
          if (dmem.gnt) begin
            dmem.req <= 1'b0;
            if (dmem.we) begin
              state_q  <= IDLE;
              wb_valid <= 1'b1;
              wb_rd    <= rd_q;
            end else if (dmem.rvalid) begin
              state_q  <= IDLE;
              wb_valid <= 1'b1;
              wb_we    <= we_q;
              wb_rd    <= rd_q;
              wb_data  <= load_data;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem.rvalid) begin
            state_q  <= IDLE;
            wb_valid <= 1'b1;
            wb_we    <= we_q;
            wb_rd    <= rd_q;
            wb_data  <= load_data;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LSU_BP_STATS_EN
  // Saturating counters of resolved control-flow ops and mispredicts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_mispred  <= '0;
      stat_branches <= '0;
    end else begin
      if (accept && is_ctrl && (stat_branches != '1)) begin
        stat_branches <= stat_branches + STAT_W'(1);
      end
      if (redirect && (stat_mispred != '1)) begin
        stat_mispred <= stat_mispred + STAT_W'(1);
      end
    end
  end
`else
  assign stat_mispred  = '0;
  assign stat_branches = '0;
`endif

endmodule
